conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
Parametrised control and output stage for one conv layer pass over an NUM_PE-wide PE cluster. Per output pixel it sequences PE clear, MAC accumulation, pipeline drain, finish and result capture. It applies a run-time selectable activation (none/ReLU/ReLU6) to every channel and buffers activated vectors in a FIFO behind a valid/ready output. It sits between the address generator / weight BRAMs / PE cluster and the OFM write-back path.

Parameters:
NUM_PE, 16, PE (output channel) count; width of pe_reset/pe_finish and lanes of pe_ofm/ofm_data
DATA_W, 8, signed width of one PE result and one activated output
LANES, 4, input channels consumed per MAC cycle (bytes per IFM word)
PIPE_LAT, 2, cycles from last fetch_en to last MAC landing in PE accumulator (BRAM read + PE pipe)
FIFO_DEPTH, 8, output vector FIFO depth (power of 2, >=2)
RELU6_MAX, 6, upper clamp for ReLU6 mode, in DATA_W integer units

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a layer pass, samples cfg_* this cycle
cfg_kernel_w  in  4  kernel width K (square KxK)
cfg_ifm_c  in  16  input channel count C
cfg_ofm_pixels  in  16  number of output pixels P to produce
cfg_act_mode  in  2  0 none, 1 ReLU, 2 ReLU6, 3 treated as 0
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of pass
fetch_en  out  1  advance address generator / BRAM read, one MAC step per cycle
done_window  out  1  pulse on last fetch_en cycle of each window
pe_reset  out  NUM_PE  clear all PE accumulators
pe_finish  out  NUM_PE  latch PE result
pe_ofm  in  NUM_PE*DATA_W  PE results, lane i at [i*DATA_W +: DATA_W], valid cycle after pe_finish, held until next pe_reset
ofm_valid  out  1  FIFO head valid
ofm_ready  in  1  downstream accept
ofm_data  out  NUM_PE*DATA_W  activated vector
ofm_pixel_idx  out  16  pixel index of ofm_data (0..P-1)

Behaviour:
- Reset: FSM to IDLE; busy, done, fetch_en, done_window, ofm_valid = 0; pe_reset, pe_finish = 0; FIFO flushed; counters 0; ofm_data/ofm_pixel_idx = 0. Reset mid-pass aborts with no done pulse.
- Window length L = K*K*ceil(C/LANES), computed once at start into a 24-bit register.
- start accepted only in IDLE; ignored while busy. If K==0, C==0 or P==0: busy stays low, done pulses the cycle after start, no outputs.
- States: IDLE -> CLEAR (1 cycle, pe_reset all ones) -> ACCUM (exactly L cycles, fetch_en=1, done_window=1 on the L-th) -> DRAIN (PIPE_LAT cycles) -> FINISH (1 cycle, pe_finish all ones) -> CAPTURE -> next pixel CLEAR, or WAIT_EMPTY after pixel P-1.
- CAPTURE: if FIFO not full, push {act(pe_ofm), pixel_idx} and leave; if full, stay. No fetch_en or pe_* activity while stalled; PE results are held.
- Per-pixel latency with FIFO not full: L+PIPE_LAT+3 cycles, CLEAR to CAPTURE inclusive.
- Activation per lane, signed DATA_W: mode 0 passthrough; mode 1 x<0 -> 0; mode 2 x<0 -> 0, x>RELU6_MAX -> RELU6_MAX, else x.
- FIFO: first-word-fall-through. ofm_valid = not empty. Pop on ofm_valid&&ofm_ready. ofm_data/ofm_pixel_idx stable while valid&&!ready. Push and pop in the same cycle when full: pop frees the slot and push succeeds in that cycle; occupancy unchanged.
- WAIT_EMPTY: when FIFO empty, done pulses 1 cycle, busy falls in the same cycle, then IDLE.
- pixel_idx counter wraps only by pass completion; never exceeds P-1.

Test Plan:
1. K=3, C=16, P=2, mode 0, ofm_ready=1, pe_ofm lanes = lane index -> fetch_en high 36 consecutive cycles per pixel; pixel 1 CLEAR 41 cycles after pixel 0 CLEAR; two vectors idx 0,1; done 1 cycle after last pop.
2. Mode 2, pe_ofm lanes {-5,0,3,6,7,127,-128,...} -> ofm_data lanes {0,0,3,6,6,6,0,...}; mode 1 same input -> {0,0,3,6,7,127,0,...}.
3. K=1, C=5, P=12, ofm_ready=0 -> L=2; after 8 captures FSM holds in CAPTURE with fetch_en=0; raise ofm_ready -> all 12 idx 0..11 delivered in order, no loss or duplicate.
4. ofm_ready toggling every cycle with FIFO full -> ofm_data stable while valid&&!ready; simultaneous push/pop keeps occupancy at FIFO_DEPTH.
5. start with C=0 -> done pulse next cycle, busy never high, ofm_valid never high; start while busy -> ignored, cfg unchanged.
6. reset asserted mid-ACCUM of pixel 3 -> next cycle all outputs 0, FIFO empty, no done; new start runs a clean pass from idx 0.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// Conv layer pass sequencer: per output pixel it walks PE clear, MAC accumulate, drain,
// finish and capture, activates every channel and queues vectors in a FWFT output FIFO.

module conv_act_lane #(
  parameter int DATA_W    = 8,
  parameter int RELU6_MAX = 6
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);
  localparam logic signed [DATA_W-1:0] CLAMP = DATA_W'(RELU6_MAX);

  logic signed [DATA_W-1:0] xs;
  assign xs = x;

  always_comb begin
    y = x;
    case (mode)
      2'd1: if (x[DATA_W-1]) y = '0;
      2'd2: begin
        if (x[DATA_W-1])    y = '0;
        else if (xs > CLAMP) y = CLAMP;
      end
      default: y = x;
    endcase
  end
endmodule

module conv_layer_sequencer #(
  parameter int NUM_PE     = 16,
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int RELU6_MAX  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               cfg_kernel_w,
  input  logic [15:0]              cfg_ifm_c,
  input  logic [15:0]              cfg_ofm_pixels,
  input  logic [1:0]               cfg_act_mode,
  output logic                     busy,
  output logic                     done,
  output logic                     fetch_en,
  output logic                     done_window,
  output logic [NUM_PE-1:0]        pe_reset,
  output logic [NUM_PE-1:0]        pe_finish,
  input  logic [NUM_PE*DATA_W-1:0] pe_ofm,
  output logic                     ofm_valid,
  input  logic                     ofm_ready,
  output logic [NUM_PE*DATA_W-1:0] ofm_data,
  output logic [15:0]              ofm_pixel_idx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_FINISH, S_CAPTURE, S_WAIT_EMPTY
  } state_t;

  typedef struct packed {
    logic [NUM_PE-1:0][DATA_W-1:0] data;
    logic [15:0]                   idx;
  } ofm_entry_t;

  state_t        state, state_nx;
  logic [23:0]   win_len, step_cnt;
  logic [DW-1:0] drain_cnt;
  logic [15:0]   pix_cnt, pix_last;
  logic [1:0]    act_mode;
  logic          done_zero;
  logic          push, pop, fifo_empty, fifo_full, last_done;
  logic [AW:0]   wr_ptr, rd_ptr;
  ofm_entry_t    mem [FIFO_DEPTH];
  ofm_entry_t    push_ent, head;

  logic [NUM_PE-1:0][DATA_W-1:0] pe_lanes, act_lanes;
  assign pe_lanes = pe_ofm;

  // Window length is latched once per pass; the divide is by a constant.
  logic [7:0]  kk;
  logic [16:0] c_grp;
  logic [23:0] win_len_calc;
  logic        cfg_zero;
  assign kk           = 8'(cfg_kernel_w) * 8'(cfg_kernel_w);
  assign c_grp        = (17'(cfg_ifm_c) + 17'(LANES - 1)) / 17'(LANES);
  assign win_len_calc = 24'(kk) * 24'(c_grp);
  assign cfg_zero     = (cfg_kernel_w == 4'd0) || (cfg_ifm_c == 16'd0) || (cfg_ofm_pixels == 16'd0);

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    conv_act_lane #(.DATA_W(DATA_W), .RELU6_MAX(RELU6_MAX)) u_act (
      .mode (act_mode),
      .x    (pe_lanes[i]),
      .y    (act_lanes[i])
    );
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && ofm_ready;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_comb begin
    push_ent.data = act_lanes;
    push_ent.idx  = pix_cnt;
  end

  always_comb begin
    state_nx    = state;
    fetch_en    = 1'b0;
    done_window = 1'b0;
    pe_reset    = '0;
    pe_finish   = '0;
    push        = 1'b0;
    case (state)
      S_IDLE:  if (start && !cfg_zero) state_nx = S_CLEAR;
      S_CLEAR: begin
        pe_reset = '1;
        state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        fetch_en = 1'b1;
        if (step_cnt == win_len - 24'd1) begin
          done_window = 1'b1;
          state_nx    = (PIPE_LAT == 0) ? S_FINISH : S_DRAIN;
        end
      end
      S_DRAIN: if (drain_cnt == DW'(PIPE_LAT - 1)) state_nx = S_FINISH;
      S_FINISH: begin
        pe_finish = '1;
        state_nx  = S_CAPTURE;
      end
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      S_CAPTURE: if (!fifo_full || pop) begin
        push     = 1'b1;
        state_nx = (pix_cnt == pix_last) ? S_WAIT_EMPTY : S_CLEAR;
      end
      S_WAIT_EMPTY: if (fifo_empty) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      win_len   <= '0;
      step_cnt  <= '0;
      drain_cnt <= '0;
      pix_cnt   <= '0;
      pix_last  <= '0;
      act_mode  <= '0;
      done_zero <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nx;
      done_zero <= (state == S_IDLE) && start && cfg_zero;
      if (state == S_IDLE && start && !cfg_zero) begin
        win_len  <= win_len_calc;
        pix_last <= cfg_ofm_pixels - 16'd1;
        act_mode <= cfg_act_mode;
        pix_cnt  <= '0;
      end
      step_cnt  <= (state == S_ACCUM && state_nx == S_ACCUM) ? step_cnt + 24'd1 : '0;
      drain_cnt <= (state == S_DRAIN && state_nx == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (push) begin
        pix_cnt <= (state_nx == S_WAIT_EMPTY) ? 16'd0 : pix_cnt + 16'd1;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  assign last_done     = (state == S_WAIT_EMPTY) && fifo_empty;
  assign done          = done_zero || last_done;
  assign busy          = (state != S_IDLE) && !last_done;
  assign ofm_valid     = !fifo_empty;
  assign ofm_data      = fifo_empty ? '0 : head.data;
  assign ofm_pixel_idx = fifo_empty ? '0 : head.idx;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer: drives passes, plays the PE cluster and
// checks timing and the activated output stream against a per-pixel arithmetic model.

module tb_conv_layer_sequencer;
  localparam int NP = 16, DW = 8, W = NP * DW;

  logic          clk = 0, reset = 1, start = 0;
  logic [3:0]    cfg_kernel_w = '0;
  logic [15:0]   cfg_ifm_c = '0, cfg_ofm_pixels = '0;
  logic [1:0]    cfg_act_mode = '0;
  logic          busy, done, fetch_en, done_window, ofm_valid;
  logic          ofm_ready = 0;
  logic [NP-1:0] pe_reset, pe_finish;
  logic [W-1:0]  pe_ofm = '0, ofm_data;
  logic [15:0]   ofm_pixel_idx;

  conv_layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_kernel_w(cfg_kernel_w), .cfg_ifm_c(cfg_ifm_c), .cfg_ofm_pixels(cfg_ofm_pixels),
    .cfg_act_mode(cfg_act_mode), .busy(busy), .done(done), .fetch_en(fetch_en),
    .done_window(done_window), .pe_reset(pe_reset), .pe_finish(pe_finish), .pe_ofm(pe_ofm),
    .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_data(ofm_data), .ofm_pixel_idx(ofm_pixel_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] data; logic [15:0] idx; } ent_t;
  ent_t got_q[$], exp_q[$];
  int clear_cyc[$], fetch_runs[$], pop_cyc[$];
  int done_cyc, done_cnt, busy_seen, valid_seen, unstable, dw_bad, dw_cnt, fin_cnt;
  int timeout, rst_zero, fetch_tot, snap_fetch, snap_fin, snap_clr, snap_fe;
  int errors = 0, checks = 0;

  function automatic logic [W-1:0] act_vec(input logic [W-1:0] v, input int mode);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) begin
      int x;
      x = $signed(v[i*DW +: DW]);
      if ((mode == 1 || mode == 2) && x < 0) x = 0;
      if (mode == 2 && x > 6) x = 6;
      r[i*DW +: DW] = x[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] make_pat(input int sel);
    logic [W-1:0] r;
    int f7 [7];
    f7 = '{-5, 0, 3, 6, 7, 127, -128};
    for (int i = 0; i < NP; i++) begin
      if (sel == 0)               r[i*DW +: DW] = DW'(i);
      else if (sel == 1 && i < 7) r[i*DW +: DW] = DW'(f7[i]);
      else                        r[i*DW +: DW] = DW'($urandom);
    end
    return r;
  endfunction

  function automatic int win_len(input int k, input int c);
    return k * k * ((c + 3) / 4);
  endfunction

  // Runs one pass from a start pulse at cycle 0, recording what the DUT did each cycle.
  task automatic run_pass(input int k, c, p, mode, rmode, hold, sel, max_cyc, abort_pix, busy_start);
    int cyc, run, pix_m, rst_at;
    bit last_dw, pv, pr;
    logic [W-1:0] pd, pat;
    logic [15:0] pi;
    ent_t e;
    clear_cyc.delete(); fetch_runs.delete(); pop_cyc.delete(); got_q.delete(); exp_q.delete();
    done_cyc = -1; done_cnt = 0; busy_seen = 0; valid_seen = 0; unstable = 0; dw_bad = 0;
    dw_cnt = 0; fin_cnt = 0; timeout = 0; rst_zero = -1; fetch_tot = 0;
    snap_fetch = -1; snap_fin = -1; snap_clr = -1; snap_fe = -1;
    run = 0; pix_m = 0; rst_at = -1; last_dw = 0; pv = 0; pr = 0; pd = '0; pi = '0;
    @(negedge clk);
    cfg_kernel_w = 4'(k); cfg_ifm_c = 16'(c); cfg_ofm_pixels = 16'(p); cfg_act_mode = 2'(mode);
    start = 1; ofm_ready = (rmode == 0);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        reset = 0;
        rst_zero = (busy === 0 && done === 0 && fetch_en === 0 && done_window === 0 &&
                    pe_reset === '0 && pe_finish === '0 && ofm_valid === 0 &&
                    ofm_data === '0 && ofm_pixel_idx === '0) ? 1 : 0;
      end
      case (rmode)
        0: ofm_ready = 1;
        1: ofm_ready = (cyc >= hold);
        2: ofm_ready = (cyc >= hold) && (cyc % 2 == 1);
        default: ofm_ready = 1'($urandom_range(0, 1));
      endcase
      if (busy) busy_seen = 1;
      if (ofm_valid) valid_seen = 1;
      if (pv && !pr && (!ofm_valid || ofm_data !== pd || ofm_pixel_idx !== pi)) unstable++;
      pv = ofm_valid; pr = ofm_ready; pd = ofm_data; pi = ofm_pixel_idx;
      if (pe_reset === '1) clear_cyc.push_back(cyc);
      if (done_window) dw_cnt++;
      if (done_window && !fetch_en) dw_bad++;
      if (fetch_en) begin
        run++; fetch_tot++;
      end else if (run > 0) begin
        fetch_runs.push_back(run);
        if (!last_dw) dw_bad++;
        run = 0;
      end
      last_dw = done_window;
      if (ofm_valid && ofm_ready) begin
        e.data = ofm_data; e.idx = ofm_pixel_idx;
        got_q.push_back(e); pop_cyc.push_back(cyc);
      end
      if (pe_finish === '1) begin
        pat = make_pat(sel);
        pe_ofm = pat;
        e.data = act_vec(pat, mode); e.idx = 16'(pix_m);
        exp_q.push_back(e);
        pix_m++; fin_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == hold - 1) begin
        snap_fetch = fetch_tot; snap_fin = fin_cnt; snap_clr = clear_cyc.size(); snap_fe = fetch_en;
      end
      if (busy_start != 0 && cyc == 5) begin
        cfg_kernel_w = 4'd2; cfg_ifm_c = 16'd16; cfg_ofm_pixels = 16'd5; cfg_act_mode = 2'd1;
        start = 1;
      end
      if (abort_pix >= 0 && rst_at < 0 && clear_cyc.size() == abort_pix + 1 &&
          cyc == clear_cyc[abort_pix] + 3) begin
        reset = 1; rst_at = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (rst_at >= 0 && cyc >= rst_at + 20) break;
      if (cyc >= max_cyc) begin
        timeout = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, fetch_en, done_window, ofm_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, fetch_en, done_window, ofm_valid});
    end
    checks++; if (pe_reset !== '0 || pe_finish !== '0) begin
      errors++; $display("FAIL reset_pe: got %h/%h want 0/0", pe_reset, pe_finish);
    end
    checks++; if (ofm_data !== '0 || ofm_pixel_idx !== '0) begin
      errors++; $display("FAIL reset_data: got %h idx %0d want 0", ofm_data, ofm_pixel_idx);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_pass(3, 16, 2, 0, 0, 0, 0, 2000, -1, 0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL basic_timeout: got %0d want 0", timeout); end
    checks++; if (fetch_runs.size() != 2) begin
      errors++; $display("FAIL basic_nwin: got %0d want 2", fetch_runs.size());
    end
    foreach (fetch_runs[i]) begin
      checks++; if (fetch_runs[i] != 36) begin errors++; $display("FAIL basic_winlen: got %0d want 36", fetch_runs[i]); end
    end
    checks++; if (dw_bad != 0 || dw_cnt != 2) begin
      errors++; $display("FAIL basic_done_window: bad %0d cnt %0d want 0/2", dw_bad, dw_cnt);
    end
    checks++; if (clear_cyc.size() != 2 || clear_cyc[0] != 1 || clear_cyc[1] - clear_cyc[0] != 41) begin
      errors++; $display("FAIL basic_clear_timing: n %0d first %0d want 2 clears at 1 and 42", clear_cyc.size(), clear_cyc.size() > 0 ? clear_cyc[0] : -1);
    end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL basic_count: got %0d want 2", got_q.size()); end
    foreach (got_q[i]) begin
      checks++; if (got_q[i].idx != 16'(i) || got_q[i].data !== make_pat(0)) begin
        errors++; $display("FAIL basic_vec: idx %0d data %h want idx %0d data %h", got_q[i].idx, got_q[i].data, i, make_pat(0));
      end
    end
    checks++; if (done_cnt != 1 || pop_cyc.size() == 0 || done_cyc != pop_cyc[pop_cyc.size()-1] + 1) begin
      errors++; $display("FAIL basic_done: cyc %0d cnt %0d want one pulse 1 cycle after last pop", done_cyc, done_cnt);
    end
  endtask

  task automatic test_activation();
    int e2 [7], e1 [7];
    logic [W-1:0] v;
    e2 = '{0, 0, 3, 6, 6, 6, 0};
    e1 = '{0, 0, 3, 6, 7, 127, 0};
    for (int m = 2; m >= 1; m--) begin
      run_pass(1, 4, 1, m, 0, 0, 1, 500, -1, 0);
      checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin
        errors++; $display("FAIL act_count mode %0d: got %0d want 1", m, got_q.size());
      end
      v = got_q.size() > 0 ? got_q[0].data : '0;
      for (int i = 0; i < 7; i++) begin
        checks++; if ($signed(v[i*DW +: DW]) != (m == 2 ? e2[i] : e1[i])) begin
          errors++; $display("FAIL act_lane mode %0d lane %0d: got %0d want %0d", m, i, $signed(v[i*DW +: DW]), m == 2 ? e2[i] : e1[i]);
        end
      end
      checks++; if (exp_q.size() == 0 || v !== exp_q[0].data) begin
        errors++; $display("FAIL act_vec mode %0d: got %h", m, v);
      end
    end
    run_pass(1, 4, 1, 3, 0, 0, 2, 500, -1, 0);
    checks++; if (got_q.size() != 1 || got_q[0].data !== exp_q[0].data) begin
      errors++; $display("FAIL act_mode3: got %h want passthrough %h", got_q.size() > 0 ? got_q[0].data : '0, exp_q.size() > 0 ? exp_q[0].data : '0);
    end
  endtask

  task automatic test_backpressure();
    run_pass(1, 5, 12, 0, 1, 150, 2, 3000, -1, 0);
    checks++; if (snap_fetch != 18 || snap_fin != 9 || snap_clr != 9 || snap_fe != 0) begin
      errors++; $display("FAIL bp_stall: fetch %0d fin %0d clr %0d fe %0d want 18 9 9 0", snap_fetch, snap_fin, snap_clr, snap_fe);
    end
    checks++; if (timeout != 0 || got_q.size() != 12 || done_cnt != 1) begin
      errors++; $display("FAIL bp_count: got %0d vecs done %0d to %0d want 12/1/0", got_q.size(), done_cnt, timeout);
    end
    foreach (got_q[i]) begin
      checks++; if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_vec %0d: got idx %0d data %h", i, got_q[i].idx, got_q[i].data);
      end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
  endtask

  task automatic test_full_toggle();
    run_pass(1, 5, 12, 0, 2, 100, 2, 3000, -1, 0);
    checks++; if (unstable != 0) begin errors++; $display("FAIL tog_stable: got %0d changes want 0", unstable); end
    checks++; if (clear_cyc.size() != 12 || pop_cyc.size() == 0 || clear_cyc[9] != pop_cyc[0] + 1) begin
      errors++; $display("FAIL tog_push_on_pop: clears %0d first pop %0d clear9 %0d want clear9 = pop+1",
                         clear_cyc.size(), pop_cyc.size() > 0 ? pop_cyc[0] : -1, clear_cyc.size() > 9 ? clear_cyc[9] : -1);
    end
    checks++; if (got_q.size() != 12 || timeout != 0) begin
      errors++; $display("FAIL tog_count: got %0d want 12", got_q.size());
    end
    foreach (got_q[i]) begin
      checks++; if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL tog_vec %0d: got idx %0d data %h", i, got_q[i].idx, got_q[i].data);
      end
    end
  endtask

  task automatic test_zero_and_busy();
    run_pass(3, 0, 4, 0, 0, 0, 2, 100, -1, 0);
    checks++; if (done_cyc != 1 || done_cnt != 1) begin
      errors++; $display("FAIL zero_done: cyc %0d cnt %0d want 1/1", done_cyc, done_cnt);
    end
    checks++; if (busy_seen != 0 || valid_seen != 0 || fetch_tot != 0) begin
      errors++; $display("FAIL zero_quiet: busy %0d valid %0d fetch %0d want 0", busy_seen, valid_seen, fetch_tot);
    end
    run_pass(1, 4, 2, 0, 0, 0, 2, 500, -1, 1);
    checks++; if (fetch_runs.size() != 2 || fetch_runs[0] != 1 || fetch_runs[1] != 1) begin
      errors++; $display("FAIL busy_start_win: n %0d want 2 windows of 1", fetch_runs.size());
    end
    checks++; if (got_q.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL busy_start_count: got %0d done %0d want 2/1", got_q.size(), done_cnt);
    end
    foreach (got_q[i]) begin
      checks++; if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL busy_start_vec %0d: got %h", i, got_q[i].data);
      end
    end
  endtask

  task automatic test_abort();
    run_pass(2, 8, 6, 0, 0, 0, 2, 2000, 3, 0);
    checks++; if (rst_zero != 1) begin errors++; $display("FAIL abort_outputs: got %0d want 1", rst_zero); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    run_pass(2, 8, 6, 0, 0, 0, 2, 2000, -1, 0);
    checks++; if (got_q.size() != 6 || done_cnt != 1 || timeout != 0) begin
      errors++; $display("FAIL abort_rerun: got %0d done %0d want 6/1", got_q.size(), done_cnt);
    end
    foreach (got_q[i]) begin
      checks++; if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_rerun_vec %0d: got idx %0d", i, got_q[i].idx);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int k, c, p, m;
      k = $urandom_range(1, 3); c = $urandom_range(1, 24); p = $urandom_range(1, 10); m = $urandom_range(0, 3);
      run_pass(k, c, p, m, 3, 0, 2, 5000, -1, 0);
      checks++; if (timeout != 0 || done_cnt != 1 || got_q.size() != p || fetch_runs.size() != p) begin
        errors++; $display("FAIL rnd_pass k%0d c%0d p%0d: vecs %0d wins %0d done %0d to %0d", k, c, p, got_q.size(), fetch_runs.size(), done_cnt, timeout);
      end
      foreach (fetch_runs[i]) begin
        checks++; if (fetch_runs[i] != win_len(k, c)) begin
          errors++; $display("FAIL rnd_winlen: got %0d want %0d", fetch_runs[i], win_len(k, c));
        end
      end
      foreach (got_q[i]) begin
        checks++; if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd_vec %0d mode %0d: got idx %0d data %h", i, m, got_q[i].idx, got_q[i].data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_activation();
    test_backpressure();
    test_full_toggle();
    test_zero_and_busy();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
